// File: rtl/ogut_pkg.sv
// Shared types and constants for the sequential grinder.
// Factors are expressed in eighths (KESIR_BIT fractional bits).
package ogut_pkg;

   typedef enum logic [1:0] {
      BOSTA = 2'd0,
      OGUT  = 2'd1,
      BITTI = 2'd2
   } durum_t;

   localparam logic [1:0] BOYUT_INCE = 2'b00;
   localparam logic [1:0] BOYUT_ORTA = 2'b01;
   localparam logic [1:0] BOYUT_KABA = 2'b10;

   localparam logic [4:0] KAT_INCE = 5'd16;
   localparam logic [4:0] KAT_ORTA = 5'd12;
   localparam logic [4:0] KAT_KABA = 5'd9;

   localparam int KESIR_BIT = 3;

endpackage

// File: rtl/ogut_katsayi.sv
// Grind mode to fixed-point factor (eighths) lookup.
// Mode 2'b11 has no factor and raises o_gecersiz.
module ogut_katsayi
   import ogut_pkg::*;
(
   input  logic [1:0] i_boyut,
   output logic [4:0] o_kat,
   output logic       o_gecersiz
);

   always_comb begin
      o_kat      = '0;
      o_gecersiz = 1'b0;
      unique case (i_boyut)
         BOYUT_INCE: o_kat = KAT_INCE;
         BOYUT_ORTA: o_kat = KAT_ORTA;
         BOYUT_KABA: o_kat = KAT_KABA;
         default:    o_gecersiz = 1'b1;
      endcase
   end

endmodule

// File: rtl/ogut_ardisik.sv
// Multi-cycle grinder: N seeds, ADIM cycles each, saturating result.
// Optional pause input enabled by defining OGUT_DURAKLAT_EN.
module ogut_ardisik
   import ogut_pkg::*;
#(
   parameter int GIRIS_W = 4,
   parameter int CIKIS_W = 5,
   parameter int ADIM    = 2
) (
   input  logic               saat,
   input  logic               reset,
   input  logic               basla,
   input  logic [GIRIS_W-1:0] cekirdekler,
   input  logic [1:0]         boyut,
`ifdef OGUT_DURAKLAT_EN
   input  logic               duraklat,
`endif
   output logic               mesgul,
   output logic               bitti,
   output logic [CIKIS_W-1:0] tanecikler,
   output logic               tasma,
   output logic               hata
);

   localparam int         ACC_W    = GIRIS_W + 5;
   localparam logic [3:0] ADIM_SON = 4'(ADIM - 1);

   durum_t               r_durum;
   durum_t               w_sonraki;
   logic [1:0]           r_boyut;
   logic [GIRIS_W-1:0]   r_kalan;
   logic [3:0]           r_adim;
   logic [ACC_W-1:0]     r_acc;
   logic [CIKIS_W-1:0]   r_tan;
   logic                 r_tasma;
   logic                 r_hata;

   logic [1:0]           w_boyut_sec;
   logic [4:0]           w_kat;
   logic                 w_gecersiz;
   logic                 w_durak;
   logic                 w_kabul;
   logic                 w_hemen;
   logic                 w_ilerle;
   logic                 w_adim_son;
   logic                 w_son;
   logic [ACC_W-1:0]     w_acc_yeni;
   logic [ACC_W-1:0]     w_sonuc;
   logic                 w_tasar;

`ifdef OGUT_DURAKLAT_EN
   assign w_durak = duraklat;
`else
   assign w_durak = 1'b0;
`endif

   // Live mode decides the early exit at accept; latched mode drives the job.
   assign w_boyut_sec = (r_durum == BOSTA) ? boyut : r_boyut;

   ogut_katsayi u_katsayi (
      .i_boyut    (w_boyut_sec),
      .o_kat      (w_kat),
      .o_gecersiz (w_gecersiz)
   );

   assign w_kabul    = (r_durum == BOSTA) && basla;
   assign w_hemen    = w_kabul &&
                       ((cekirdekler == '0) || w_gecersiz);
   assign w_ilerle   = (r_durum == OGUT) && !w_durak;
   assign w_adim_son = (r_adim == ADIM_SON);
   assign w_son      = w_ilerle && w_adim_son &&
                       (r_kalan == GIRIS_W'(1));
   assign w_acc_yeni = r_acc + ACC_W'(w_kat);
   assign w_sonuc    = w_acc_yeni >> KESIR_BIT;
   assign w_tasar    = (w_sonuc >> CIKIS_W) != '0;

   always_ff @(posedge saat) begin
      if (reset) r_durum <= BOSTA;
      else       r_durum <= w_sonraki;
   end

   always_comb begin
      w_sonraki = r_durum;
      unique case (r_durum)
         BOSTA: begin
            if (basla) w_sonraki = w_hemen ? BITTI : OGUT;
         end
         OGUT: begin
            if (w_son) w_sonraki = BITTI;
         end
         BITTI:   w_sonraki = BOSTA;
         default: w_sonraki = BOSTA;
      endcase
   end

   always_comb begin
      mesgul = (r_durum != BOSTA);
      bitti  = (r_durum == BITTI);
   end

   always_ff @(posedge saat) begin
      if (reset) begin
         r_boyut <= '0;
         r_kalan <= '0;
         r_adim  <= '0;
         r_acc   <= '0;
         r_tan   <= '0;
         r_tasma <= 1'b0;
         r_hata  <= 1'b0;
      end else if (w_kabul) begin
         r_boyut <= boyut;
         r_kalan <= cekirdekler;
         r_adim  <= '0;
         r_acc   <= '0;
         if (w_hemen) begin
            r_tan   <= '0;
            r_tasma <= 1'b0;
            r_hata  <= w_gecersiz;
         end
      end else if (w_ilerle) begin
         if (w_adim_son) begin
            r_adim  <= '0;
            r_acc   <= w_acc_yeni;
            r_kalan <= r_kalan - GIRIS_W'(1);
            if (w_son) begin
               r_tan   <= w_tasar ? '1 : CIKIS_W'(w_sonuc);
               r_tasma <= w_tasar;
               r_hata  <= 1'b0;
            end
         end else begin
            r_adim <= r_adim + 4'd1;
         end
      end
   end

   assign tanecikler = r_tan;
   assign tasma      = r_tasma;
   assign hata       = r_hata;

endmodule

// File: tb/tb_ogut_ardisik.sv
// Bench for ogut_ardisik: behavioural model, per-cycle compare, directed pins.
// Two instances share inputs: default widths and a 4-bit result.
module tb_ogut_ardisik;

   localparam int ADIM = 2;

   logic       saat = 1'b0;
   logic       reset = 1'b1;
   logic       basla = 1'b0;
   logic [3:0] cekirdekler = '0;
   logic [1:0] boyut = '0;
   logic       duraklat = 1'b0;

   logic       a_mesgul, a_bitti, a_tasma, a_hata;
   logic [4:0] a_tan;
   logic       b_mesgul, b_bitti, b_tasma, b_hata;
   logic [3:0] b_tan;

   int n_checks = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   ogut_ardisik #(.GIRIS_W(4), .CIKIS_W(5), .ADIM(ADIM)) dut_a (
      .saat(saat), .reset(reset), .basla(basla),
      .cekirdekler(cekirdekler), .boyut(boyut),
`ifdef OGUT_DURAKLAT_EN
      .duraklat(duraklat),
`endif
      .mesgul(a_mesgul), .bitti(a_bitti), .tanecikler(a_tan),
      .tasma(a_tasma), .hata(a_hata)
   );

   ogut_ardisik #(.GIRIS_W(4), .CIKIS_W(4), .ADIM(ADIM)) dut_b (
      .saat(saat), .reset(reset), .basla(basla),
      .cekirdekler(cekirdekler), .boyut(boyut),
`ifdef OGUT_DURAKLAT_EN
      .duraklat(duraklat),
`endif
      .mesgul(b_mesgul), .bitti(b_bitti), .tanecikler(b_tan),
      .tasma(b_tasma), .hata(b_hata)
   );

   always #5 saat = ~saat;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int doy(input int r, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (r > mx) ? mx : r;
   endfunction

   // Model: 0 idle, 1 grinding, 2 done pulse
   int kat[4] = '{16, 12, 9, 0};
   int m_faz = 0;
   int m_kalan = 0;
   int m_bek = 0;
   int m_r = 0;
   int m_hata = 0;

   always @(posedge saat) begin
      if (reset) begin
         m_faz = 0;
         m_r = 0;
         m_hata = 0;
      end else begin
         case (m_faz)
            0: if (basla) begin
               if (cekirdekler == 0 || boyut == 3) begin
                  m_r = 0;
                  m_hata = (boyut == 3) ? 1 : 0;
                  m_faz = 2;
               end else begin
                  m_kalan = int'(cekirdekler) * ADIM;
                  m_bek = (int'(cekirdekler) * kat[boyut]) / 8;
                  m_faz = 1;
               end
            end
            1: if (!duraklat) begin
               m_kalan--;
               if (m_kalan == 0) begin
                  m_r = m_bek;
                  m_hata = 0;
                  m_faz = 2;
               end
            end
            default: m_faz = 0;
         endcase
      end
   end

   always @(negedge saat) begin
      if (chk_en) begin
         chk("A.mesgul", a_mesgul, m_faz != 0);
         chk("A.bitti", a_bitti, m_faz == 2);
         chk("A.tanecikler", a_tan, doy(m_r, 5));
         chk("A.tasma", a_tasma, m_r > 31);
         chk("A.hata", a_hata, m_hata);
         chk("B.mesgul", b_mesgul, m_faz != 0);
         chk("B.bitti", b_bitti, m_faz == 2);
         chk("B.tanecikler", b_tan, doy(m_r, 4));
         chk("B.tasma", b_tasma, m_r > 15);
         chk("B.hata", b_hata, m_hata);
      end
   end

   task automatic adim;
      @(posedge saat);
      #1;
   endtask

   task automatic is_calis(input int n, input int b, input int lat,
                           input int ta, input int tb, input int sb,
                           input int h);
      int k;
      cekirdekler = 4'(n);
      boyut = 2'(b);
      basla = 1'b1;
      adim();
      basla = 1'b0;
      chk("job.mesgul_E0", a_mesgul, 1);
      k = 0;
      while (!a_bitti && k < 100) begin
         adim();
         k++;
      end
      chk("job.latency", k, lat);
      chk("job.A.tan", a_tan, ta);
      chk("job.A.tasma", a_tasma, 0);
      chk("job.B.tan", b_tan, tb);
      chk("job.B.tasma", b_tasma, sb);
      chk("job.hata", a_hata, h);
      adim();
      chk("job.bitti_low", a_bitti, 0);
   endtask

   initial begin
      int pulses;
      int seen;
      int k;
      reset = 1'b1;
      adim();
      adim();
      chk_en = 1'b1;
      chk("rst.mesgul", a_mesgul, 0);
      chk("rst.bitti", a_bitti, 0);
      chk("rst.tan", a_tan, 0);
      reset = 1'b0;

      is_calis(5, 1, 10, 7, 7, 0, 0);
      is_calis(15, 2, 30, 16, 15, 1, 0);
      is_calis(15, 0, 30, 30, 15, 1, 0);
      is_calis(12, 0, 24, 24, 15, 1, 0);
      is_calis(0, 1, 0, 0, 0, 0, 0);
      is_calis(7, 3, 0, 0, 0, 0, 1);

      // restart request while grinding is dropped
      cekirdekler = 4'd3;
      boyut = 2'd1;
      basla = 1'b1;
      adim();
      basla = 1'b0;
      adim();
      adim();
      cekirdekler = 4'd9;
      boyut = 2'd0;
      basla = 1'b1;
      adim();
      basla = 1'b0;
      pulses = 0;
      seen = -1;
      for (int i = 0; i < 15; i++) begin
         if (a_bitti) begin
            pulses++;
            seen = int'(a_tan);
         end
         adim();
      end
      chk("repulse.count", pulses, 1);
      chk("repulse.tan", seen, 4);

      // reset mid-job discards it
      cekirdekler = 4'd4;
      boyut = 2'd0;
      basla = 1'b1;
      adim();
      basla = 1'b0;
      adim();
      adim();
      adim();
      reset = 1'b1;
      adim();
      chk("midrst.mesgul", a_mesgul, 0);
      chk("midrst.tan", a_tan, 0);
      chk("midrst.bitti", a_bitti, 0);
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         if (a_bitti) pulses++;
         adim();
      end
      chk("midrst.no_bitti", pulses, 0);
      is_calis(4, 0, 8, 8, 8, 0, 0);

`ifdef OGUT_DURAKLAT_EN
      cekirdekler = 4'd2;
      boyut = 2'd0;
      basla = 1'b1;
      adim();
      basla = 1'b0;
      duraklat = 1'b1;
      adim();
      adim();
      adim();
      duraklat = 1'b0;
      k = 3;
      while (!a_bitti && k < 100) begin
         adim();
         k++;
      end
      chk("pause.latency", k, 7);
      chk("pause.tan", a_tan, 4);
      adim();
`else
      k = 0;
`endif

      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         basla = ($urandom_range(0, 3) == 0);
         cekirdekler = 4'($urandom);
         boyut = 2'($urandom);
`ifdef OGUT_DURAKLAT_EN
         duraklat = ($urandom_range(0, 3) == 0);
`endif
         adim();
      end
      reset = 1'b0;
      basla = 1'b0;
      duraklat = 1'b0;
      repeat (40) adim();

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_err);
      $finish;
   end

endmodule
